// File: rtl/terminal_request_tx.sv
// Terminal-side serial transmitter: frames one access request (start, 6 data, even parity,
// stop), waits for the controller's ACK, and resends on timeout until the retries run out.
module terminal_request_tx #(
  parameter int unsigned BIT_TICKS   = 4,
  parameter int unsigned ACK_TIMEOUT = 32,
  parameter int unsigned MAX_RETRY   = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [0:2] USER,
  input  logic [0:2] FUNC,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic       ACK,
  output logic       TX,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR
);

  localparam int unsigned TickW  = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
  localparam int unsigned WaitW  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [TickW-1:0]  TickLast = TickW'(BIT_TICKS - 1);
  localparam logic [WaitW-1:0]  WaitLast = WaitW'(ACK_TIMEOUT - 1);
  localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);

  typedef enum logic [2:0] {
    StIdle, StStart, StData, StParity, StStop, StWaitAck, StFinish
  } state_e;

  state_e            state_q;
  logic [5:0]        frame_q;
  logic [TickW-1:0]  tick_q;
  logic [2:0]        bit_cnt_q;
  logic [WaitW-1:0]  wait_q;
  logic [RetryW-1:0] retry_q;
  logic              tx_q, busy_q, ready_q, done_q, err_q;
  logic              bit_end;
  logic              in_frame;

  assign bit_end  = (tick_q == TickLast);
  assign in_frame = (state_q == StStart) || (state_q == StData) ||
                    (state_q == StParity) || (state_q == StStop);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= StIdle;
      frame_q   <= '0;
      tick_q    <= '0;
      bit_cnt_q <= '0;
      wait_q    <= '0;
      retry_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (in_frame) begin
        tick_q <= bit_end ? '0 : tick_q + 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (REQ_VALID) begin
            // frame_q[0] is the first data bit on the line (USER[0])
            frame_q   <= {FUNC[2], FUNC[1], FUNC[0], USER[2], USER[1], USER[0]};
            state_q   <= StStart;
            tx_q      <= 1'b0;
            tick_q    <= '0;
            retry_q   <= '0;
            busy_q    <= 1'b1;
            ready_q   <= 1'b0;
          end
        end
        StStart: begin
          if (bit_end) begin
            state_q   <= StData;
            bit_cnt_q <= '0;
            tx_q      <= frame_q[0];
          end
        end
        StData: begin
          if (bit_end) begin
            if (bit_cnt_q == 3'd5) begin
              state_q <= StParity;
              tx_q    <= ^frame_q;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              tx_q      <= frame_q[bit_cnt_q + 3'd1];
            end
          end
        end
        StParity: begin
          if (bit_end) begin
            state_q <= StStop;
            tx_q    <= 1'b1;
          end
        end
        StStop: begin
          if (bit_end) begin
            state_q <= StWaitAck;
            wait_q  <= '0;
          end
        end
        StWaitAck: begin
          // ACK on the expiry cycle still wins over the timeout
          if (ACK) begin
            done_q  <= 1'b1;
            state_q <= StFinish;
          end else if (wait_q == WaitLast) begin
            if (retry_q < RetryMax) begin
              retry_q <= retry_q + 1'b1;
              state_q <= StStart;
              tx_q    <= 1'b0;
              tick_q  <= '0;
            end else begin
              err_q   <= 1'b1;
              state_q <= StFinish;
            end
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        StFinish: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign TX        = tx_q;
  assign BUSY      = busy_q;
  assign REQ_READY = ready_q;
  assign DONE      = done_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_terminal_request_tx.sv
// Directed bench for terminal_request_tx: frame contents, parity, ACK handling, retries,
// mid-frame reset and back-to-back acceptance.
module tb_terminal_request_tx;

  localparam int BT = 4;
  localparam int AT = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [0:2] user, func;
  logic       req_valid, ack;
  logic       req_ready, tx, busy, done, err;

  int n_checks = 0;
  int n_fail   = 0;

  terminal_request_tx #(.BIT_TICKS(BT), .ACK_TIMEOUT(AT), .MAX_RETRY(2)) dut (
    .CLK(clk), .RST_N(rst_n), .USER(user), .FUNC(func), .REQ_VALID(req_valid),
    .REQ_READY(req_ready), .ACK(ack), .TX(tx), .BUSY(busy), .DONE(done), .ERR(err)
  );

  always #5 clk = ~clk;

  // Advance one clock; sampling happens 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one accepting edge; afterwards the DUT is in its first START cycle.
  task automatic send(input logic [0:2] u, input logic [0:2] f, input bit keep_valid);
    user      = u;
    func      = f;
    req_valid = 1'b1;
    tick();
    if (!keep_valid) req_valid = 1'b0;
  endtask

  // Record 9 bit periods of TX (time order in bit i); pulses ACK on cycle ack_at if >= 0.
  task automatic capture(input int ack_at, output logic [8:0] bits, output bit stable,
                         output bit done_seen);
    int n = 0;
    stable    = 1'b1;
    done_seen = 1'b0;
    bits      = '0;
    for (int i = 0; i < 9; i++) begin
      for (int t = 0; t < BT; t++) begin
        if (t == 0) bits[i] = tx;
        else if (tx !== bits[i]) stable = 1'b0;
        if (done === 1'b1) done_seen = 1'b1;
        ack = (n == ack_at);
        n++;
        tick();
      end
    end
    ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; ack = 1'b0; user = '0; func = '0;
    tick(); tick();
    rst_n = 1'b1;
    n_checks++;
    if ({tx, req_ready, busy, done, err} !== 5'b11000) begin
      n_fail++;
      $display("FAIL reset_outputs got tx/rdy/busy/done/err=%b want 11000",
               {tx, req_ready, busy, done, err});
    end
  endtask

  task automatic test_basic_frame();
    logic [8:0] bits; bit stable, ds;
    send(3'b101, 3'b011, 1'b0);
    n_checks++;
    if ({busy, req_ready} !== 2'b10) begin
      n_fail++; $display("FAIL accept_flags got busy/rdy=%b want 10", {busy, req_ready});
    end
    capture(-1, bits, stable, ds);
    n_checks++;
    if (bits !== 9'b101101010 || !stable) begin
      n_fail++; $display("FAIL frame_101_011 got %b stable=%0d want 101101010", bits, stable);
    end
    tick(); tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_checks++;
    if ({done, err, busy, req_ready, tx} !== 5'b10101) begin
      n_fail++; $display("FAIL done_pulse got done/err/busy/rdy/tx=%b want 10101",
                         {done, err, busy, req_ready, tx});
    end
    tick();
    n_checks++;
    if ({done, busy, req_ready} !== 3'b001) begin
      n_fail++; $display("FAIL after_done got done/busy/rdy=%b want 001", {done, busy, req_ready});
    end
  endtask

  task automatic test_parity();
    logic [8:0] bits; bit stable, ds;
    send(3'b111, 3'b001, 1'b0);
    capture(-1, bits, stable, ds);
    n_checks++;
    if (bits !== 9'b101001110 || !stable) begin
      n_fail++; $display("FAIL parity_even4 got %b want 101001110", bits);
    end
    ack = 1'b1; tick(); ack = 1'b0; tick();
    send(3'b100, 3'b000, 1'b0);
    capture(-1, bits, stable, ds);
    n_checks++;
    if (bits !== 9'b110000010 || !stable) begin
      n_fail++; $display("FAIL parity_odd1 got %b want 110000010", bits);
    end
    ack = 1'b1; tick(); ack = 1'b0;
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL parity_done got %b want 1", done);
    end
    tick();
  endtask

  task automatic test_retry_err();
    logic [8:0] bits; bit stable, ds; bit bad;
    send(3'b101, 3'b011, 1'b0);
    for (int f = 0; f < 3; f++) begin
      capture(-1, bits, stable, ds);
      n_checks++;
      if (bits !== 9'b101101010 || !stable || ds) begin
        n_fail++; $display("FAIL retry_frame%0d got %b done_seen=%0d want 101101010", f, bits, ds);
      end
      bad = 1'b0;
      for (int c = 0; c < AT; c++) begin
        if (tx !== 1'b1 || done !== 1'b0 || err !== 1'b0 || busy !== 1'b1) bad = 1'b1;
        tick();
      end
      n_checks++;
      if (bad) begin
        n_fail++; $display("FAIL retry_wait%0d got line activity in wait want idle-high", f);
      end
    end
    n_checks++;
    if ({err, done, busy, tx} !== 4'b1011) begin
      n_fail++; $display("FAIL err_pulse got err/done/busy/tx=%b want 1011", {err, done, busy, tx});
    end
    tick();
    n_checks++;
    if ({err, busy, req_ready} !== 3'b001) begin
      n_fail++; $display("FAIL after_err got err/busy/rdy=%b want 001", {err, busy, req_ready});
    end
  endtask

  task automatic test_ack_ignored();
    logic [8:0] bits; bit stable, ds;
    send(3'b111, 3'b001, 1'b0);
    capture(10, bits, stable, ds);
    n_checks++;
    if (bits !== 9'b101001110 || ds) begin
      n_fail++; $display("FAIL ack_in_data got %b done_seen=%0d want 101001110 0", bits, ds);
    end
    for (int c = 0; c < AT; c++) tick();
    capture(-1, bits, stable, ds);
    n_checks++;
    if (bits !== 9'b101001110 || !stable) begin
      n_fail++; $display("FAIL ack_ignored_retry got %b want 101001110", bits);
    end
    ack = 1'b1; tick(); ack = 1'b0;
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL retry_ack_done got %b want 1", done);
    end
    tick();
  endtask

  task automatic test_mid_reset();
    logic [8:0] bits; bit stable, ds;
    send(3'b111, 3'b111, 1'b0);
    for (int c = 0; c < 10; c++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++;
    if ({tx, req_ready, busy} !== 3'b110) begin
      n_fail++; $display("FAIL mid_reset got tx/rdy/busy=%b want 110", {tx, req_ready, busy});
    end
    send(3'b100, 3'b000, 1'b0);
    capture(-1, bits, stable, ds);
    n_checks++;
    if (bits !== 9'b110000010 || !stable) begin
      n_fail++; $display("FAIL post_reset_frame got %b want 110000010", bits);
    end
    ack = 1'b1; tick(); ack = 1'b0; tick();
  endtask

  task automatic test_back_to_back();
    logic [8:0] bits; bit stable, ds;
    send(3'b101, 3'b011, 1'b1);
    user = 3'b100; func = 3'b000;
    capture(-1, bits, stable, ds);
    n_checks++;
    if (bits !== 9'b101101010 || !stable) begin
      n_fail++; $display("FAIL latched_frame got %b want 101101010", bits);
    end
    for (int c = 0; c < AT - 1; c++) tick();
    ack = 1'b1; tick(); ack = 1'b0;
    n_checks++;
    if ({done, err, busy} !== 3'b101) begin
      n_fail++; $display("FAIL ack_at_timeout got done/err/busy=%b want 101", {done, err, busy});
    end
    tick();
    n_checks++;
    if ({done, req_ready, busy} !== 3'b010) begin
      n_fail++; $display("FAIL b2b_idle got done/rdy/busy=%b want 010", {done, req_ready, busy});
    end
    tick();
    n_checks++;
    if ({busy, req_ready, tx} !== 3'b100) begin
      n_fail++; $display("FAIL b2b_accept got busy/rdy/tx=%b want 100", {busy, req_ready, tx});
    end
    req_valid = 1'b0;
    capture(-1, bits, stable, ds);
    n_checks++;
    if (bits !== 9'b110000010 || !stable) begin
      n_fail++; $display("FAIL b2b_frame got %b want 110000010", bits);
    end
    ack = 1'b1; tick(); ack = 1'b0; tick();
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_parity();
    test_retry_err();
    test_ack_ignored();
    test_mid_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
